// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two writeback requesters (ALU, load)
// share one register-file write port through a round-robin grant.
// The winning request is registered into a one-hot WriteCode, RegWrite and RegData.
// Build option REGFILE_WB_SCOREBOARD_EN adds a pending-write scoreboard with
// issue-time set, writeback-time clear and two busy read ports.
module regfile_wb_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
`ifdef REGFILE_WB_SCOREBOARD_EN
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  SelA,
    input  logic [4:0]  SelB,
    output logic        busy_a,
    output logic        busy_b,
`endif
    output logic [31:0] WriteCode,
    output logic        RegWrite,
    output logic [31:0] RegData
);

    localparam int unsigned AddrW   = 5;
    localparam int unsigned DataW   = 32;
    localparam int unsigned NumRegs = 32;

    typedef struct packed {
        logic [AddrW-1:0] addr;
        logic [DataW-1:0] data;
    } wbReq_t;

    logic   prio;
    logic   grant0;
    logic   grant1;
    logic   anyGrant;
    wbReq_t selReq;
    logic   selNonZero;

    // Round-robin grant: a lone valid always wins, a tie goes to prio.
    // Reset and hold both force the readys low.
    always_comb begin
        grant0 = reset & ~hold & req0_valid & (~req1_valid | ~prio);
        grant1 = reset & ~hold & req1_valid & (~req0_valid |  prio);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign anyGrant   = grant0 | grant1;

    // Select the payload of the granted requester.
    always_comb begin
        selReq = '0;
        if (grant1) begin
            selReq.addr = req1_addr;
            selReq.data = req1_data;
        end else begin
            selReq.addr = req0_addr;
            selReq.data = req0_data;
        end
        selNonZero = (selReq.addr != AddrW'(0));
    end

    // Priority pointer and registered write-port outputs; $0 writes are swallowed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio      <= 1'b0;
            RegWrite  <= 1'b0;
            WriteCode <= '0;
            RegData   <= '0;
        end else begin
            if (anyGrant) begin
                prio    <= grant0;
                RegData <= selReq.data;
            end
            RegWrite  <= anyGrant & selNonZero;
            WriteCode <= (anyGrant & selNonZero) ? (NumRegs'(1) << selReq.addr) : '0;
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NumRegs-1:0] pending;
    logic [NumRegs-1:0] setMask;
    logic [NumRegs-1:0] clrMask;

    // Issue sets, writeback clears; a coincident set on the same bit wins.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (issue_valid) begin
            setMask = NumRegs'(1) << issue_addr;
        end
        if (anyGrant) begin
            clrMask = NumRegs'(1) << selReq.addr;
        end
        setMask[0] = 1'b0;
    end

    // Pending-write vector; bit 0 never set since $0 is hard-wired.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clrMask) | setMask;
        end
    end

    assign busy_a = pending[SelA];
    assign busy_b = pending[SelB];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change 1 ns after a rising edge; readys are sampled 1 ns later and
// registered outputs 1 ns after the following rising edge.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [31:0] WriteCode;
    logic        RegWrite;
    logic [31:0] RegData;
`ifdef REGFILE_WB_SCOREBOARD_EN
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  SelA;
    logic [4:0]  SelB;
    logic        busy_a;
    logic        busy_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .hold       (hold),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
`ifdef REGFILE_WB_SCOREBOARD_EN
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .SelA       (SelA),
        .SelB       (SelB),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
`endif
        .WriteCode  (WriteCode),
        .RegWrite   (RegWrite),
        .RegData    (RegData)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chkReady(input string tag, input logic e0, input logic e1);
        #1;
        check({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, e0});
        check({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, e1});
    endtask

    task automatic chkOut(input string tag, input logic eWr, input logic [31:0] eCode, input logic [31:0] eData);
        check({tag, ".RegWrite"},  {31'd0, RegWrite}, {31'd0, eWr});
        check({tag, ".WriteCode"}, WriteCode, eCode);
        check({tag, ".RegData"},   RegData, eData);
    endtask

    initial begin
        reset = 1'b0; hold = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
`ifdef REGFILE_WB_SCOREBOARD_EN
        issue_valid = 1'b0; issue_addr = '0; SelA = '0; SelB = '0;
`endif
        // reset state: outputs clear, readys low even with a valid present
        cyc(); cyc();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        chkReady("rst", 1'b0, 1'b0);
        chkOut("rst", 1'b0, 32'h0, 32'h0);

        // single transfer in first cycle after reset release
        cyc();
        reset = 1'b1;
        chkReady("first", 1'b1, 1'b0);
        cyc();
        req0_valid = 1'b0;
        chkOut("first", 1'b1, 32'h0000_0020, 32'hDEADBEEF);
        cyc();
        chkOut("idle", 1'b0, 32'h0, 32'hDEADBEEF);

        // reset pulse so the both-valid run starts at prio=0
        reset = 1'b0;
        cyc();
        reset = 1'b1;

        // both valid for four cycles: grants 0,1,0,1 with no bubble
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA0A0_0001;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB0B0_0002;
        chkReady("rr1", 1'b1, 1'b0);
        cyc();
        chkOut("rr1", 1'b1, 32'h0000_0002, 32'hA0A0_0001);
        req0_addr = 5'd3; req0_data = 32'hA0A0_0003;
        chkReady("rr2", 1'b0, 1'b1);
        cyc();
        chkOut("rr2", 1'b1, 32'h0000_0004, 32'hB0B0_0002);
        req1_addr = 5'd4; req1_data = 32'hB0B0_0004;
        chkReady("rr3", 1'b1, 1'b0);
        cyc();
        chkOut("rr3", 1'b1, 32'h0000_0008, 32'hA0A0_0003);
        chkReady("rr4", 1'b0, 1'b1);
        cyc();
        chkOut("rr4", 1'b1, 32'h0000_0010, 32'hB0B0_0004);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // transfer to $0: accepted but no write strobe
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h12345678;
        chkReady("zero", 1'b0, 1'b1);
        cyc();
        req1_valid = 1'b0;
        check("zero.RegWrite", {31'd0, RegWrite}, 32'd0);
        check("zero.WriteCode", WriteCode, 32'h0);

        // lone req0 grant moves prio to port 1
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h0000_0066;
        chkReady("pre", 1'b1, 1'b0);
        cyc();
        req0_valid = 1'b0;
        chkOut("pre", 1'b1, 32'h0000_0040, 32'h0000_0066);

        // hold for three cycles with both valid: nothing granted, prio kept
        hold = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h0000_00AA;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h0000_00BB;
        for (int i = 0; i < 3; i++) begin
            chkReady("hold", 1'b0, 1'b0);
            cyc();
            check("hold.RegWrite", {31'd0, RegWrite}, 32'd0);
        end
        hold = 1'b0;
        chkReady("unhold", 1'b0, 1'b1);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chkOut("unhold", 1'b1, 32'h0000_0800, 32'h0000_00BB);

        // reset right after a transfer discards the pending write
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0000_0099;
        cyc();
        req0_valid = 1'b0;
        chkOut("mid", 1'b1, 32'h0000_0200, 32'h0000_0099);
        reset = 1'b0;
        #1;
        chkOut("midrst", 1'b0, 32'h0, 32'h0);
        cyc();
        reset = 1'b1;
        cyc();
        check("post1.RegWrite", {31'd0, RegWrite}, 32'd0);
        cyc();
        check("post2.RegWrite", {31'd0, RegWrite}, 32'd0);

`ifdef REGFILE_WB_SCOREBOARD_EN
        // scoreboard: issue sets, coincident set beats clear, lone transfer clears
        issue_valid = 1'b1; issue_addr = 5'd7;
        cyc();
        issue_valid = 1'b0;
        SelA = 5'd7; SelB = 5'd3;
        #1;
        check("sb.set.busy_a", {31'd0, busy_a}, 32'd1);
        check("sb.set.busy_b", {31'd0, busy_b}, 32'd0);
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0777;
        issue_valid = 1'b1; issue_addr = 5'd7;
        cyc();
        issue_valid = 1'b0; req0_valid = 1'b0;
        #1;
        check("sb.both.busy_a", {31'd0, busy_a}, 32'd1);
        req0_valid = 1'b1;
        cyc();
        req0_valid = 1'b0;
        #1;
        check("sb.clr.busy_a", {31'd0, busy_a}, 32'd0);
        issue_valid = 1'b1; issue_addr = 5'd0;
        cyc();
        issue_valid = 1'b0;
        SelB = 5'd0;
        #1;
        check("sb.zero.busy_b", {31'd0, busy_b}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
